// File: rtl/mc_pkg.sv
// Shared types and constants for the memory-controller responder slice.
package mc_pkg;

    localparam int LAT_CNT_W = 4;

    // Out-of-range response word; responders truncate it to their data width (up to 64 bits).
    localparam logic [63:0] MC_ERR_WORD = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } mc_state_t;

endpackage

// File: rtl/mc_ram.sv
// Single-port word RAM with synchronous write and read-before-write synchronous read.
module mc_ram #(
    parameter int DEPTH_LOG2 = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  en,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];

    // rdata only moves on an enabled access, so it holds steady for the response phase.
    always_ff @(posedge CLK) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mc_responder.sv
// Memory-side responder: one request at a time, one response after ACCESS_LATENCY cycles.
// Optional MC_BOUNDS_CHECK_EN rejects addresses beyond the RAM depth with MC_ERR_WORD.
module mc_responder
    import mc_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int DEPTH_LOG2     = 10,
    parameter int ACCESS_LATENCY = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  SLAVE_RECEIVE_ADDR_VALID,
    input  logic [ADDR_WIDTH-1:0] SLAVE_RECEIVE_ADDR,
    input  logic                  SLAVE_RECEIVE_DATA_VALID,
    input  logic [DATA_WIDTH-1:0] SLAVE_RECEIVE_DATA,
    output logic                  SLAVE_RECEIVE_READY,
    output logic                  SLAVE_SEND_VALID,
    output logic [DATA_WIDTH-1:0] SLAVE_SEND_DATA,
    input  logic                  SLAVE_SEND_READY
);

    localparam logic [LAT_CNT_W-1:0] LAT_LOAD =
        (ACCESS_LATENCY >= 2) ? LAT_CNT_W'(ACCESS_LATENCY - 2) : '0;
    localparam logic [DATA_WIDTH-1:0] ERR_WORD = DATA_WIDTH'(MC_ERR_WORD);

    mc_state_t             state;
    mc_state_t             state_nxt;
    logic [LAT_CNT_W-1:0]  lat_cnt;
    logic                  accept;
    logic                  addr_oor;
    logic                  ram_we;
    logic                  resp_from_ram;
    logic [DATA_WIDTH-1:0] resp_q;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic [DEPTH_LOG2-1:0] index;

    assign index  = SLAVE_RECEIVE_ADDR[DEPTH_LOG2-1:0];
    assign accept = SLAVE_RECEIVE_ADDR_VALID && SLAVE_RECEIVE_READY;

`ifdef MC_BOUNDS_CHECK_EN
    assign addr_oor = |SLAVE_RECEIVE_ADDR[ADDR_WIDTH-1:DEPTH_LOG2];
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^SLAVE_RECEIVE_ADDR[ADDR_WIDTH-1:DEPTH_LOG2];
    assign addr_oor       = 1'b0;
`endif

    assign ram_we = accept && SLAVE_RECEIVE_DATA_VALID && !addr_oor;

    mc_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .CLK   (CLK),
        .en    (accept),
        .we    (ram_we),
        .addr  (index),
        .wdata (SLAVE_RECEIVE_DATA),
        .rdata (ram_rdata)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = (ACCESS_LATENCY == 1) ? S_RESP : S_WAIT;
            S_WAIT: if (lat_cnt == '0) state_nxt = S_RESP;
            S_RESP: if (SLAVE_SEND_READY) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            lat_cnt <= '0;
        end else if (accept) begin
            lat_cnt <= LAT_LOAD;
        end else if (state == S_WAIT && lat_cnt != '0) begin
            lat_cnt <= lat_cnt - 1'b1;
        end
    end

    // Read data lives in the RAM output register; resp_q carries write echoes and error words.
    always_ff @(posedge CLK) begin
        if (RST) begin
            resp_q        <= '0;
            resp_from_ram <= 1'b0;
        end else if (accept) begin
            resp_q        <= addr_oor ? ERR_WORD : SLAVE_RECEIVE_DATA;
            resp_from_ram <= !SLAVE_RECEIVE_DATA_VALID && !addr_oor;
        end
    end

    always_comb begin
        SLAVE_RECEIVE_READY = (state == S_IDLE) && !RST;
        SLAVE_SEND_VALID    = (state == S_RESP);
        SLAVE_SEND_DATA     = resp_from_ram ? ram_rdata : resp_q;
    end

endmodule

// File: tb/tb_mc_responder.sv
// Directed self-checking bench: latency-2 and latency-1 responders side by side.
module tb_mc_responder;

    logic        CLK = 1'b0;
    logic        rst  [2];
    logic        av   [2];
    logic [31:0] addr [2];
    logic        dv   [2];
    logic [31:0] wd   [2];
    logic        rdy  [2];
    logic        sv   [2];
    logic [31:0] sd   [2];
    logic        sr   [2];
    int          resp_cnt [2];
    int          checks = 0;
    int          errors = 0;
    int          base;

    always #5 CLK = ~CLK;

    mc_responder #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_LOG2(10), .ACCESS_LATENCY(2)
    ) dut_l2 (
        .CLK(CLK), .RST(rst[0]),
        .SLAVE_RECEIVE_ADDR_VALID(av[0]), .SLAVE_RECEIVE_ADDR(addr[0]),
        .SLAVE_RECEIVE_DATA_VALID(dv[0]), .SLAVE_RECEIVE_DATA(wd[0]),
        .SLAVE_RECEIVE_READY(rdy[0]), .SLAVE_SEND_VALID(sv[0]),
        .SLAVE_SEND_DATA(sd[0]), .SLAVE_SEND_READY(sr[0])
    );

    mc_responder #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_LOG2(10), .ACCESS_LATENCY(1)
    ) dut_l1 (
        .CLK(CLK), .RST(rst[1]),
        .SLAVE_RECEIVE_ADDR_VALID(av[1]), .SLAVE_RECEIVE_ADDR(addr[1]),
        .SLAVE_RECEIVE_DATA_VALID(dv[1]), .SLAVE_RECEIVE_DATA(wd[1]),
        .SLAVE_RECEIVE_READY(rdy[1]), .SLAVE_SEND_VALID(sv[1]),
        .SLAVE_SEND_DATA(sd[1]), .SLAVE_SEND_READY(sr[1])
    );

    always @(posedge CLK) begin
        for (int d = 0; d < 2; d++) begin
            if (rst[d]) resp_cnt[d] <= 0;
            else if (sv[d] && sr[d]) resp_cnt[d] <= resp_cnt[d] + 1;
        end
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic xact(input int d, input logic [31:0] a, input logic we,
                        input logic [31:0] data, input logic [31:0] exp, input int lat);
        int n;
        chk("ready_pre", 32'(rdy[d]), 32'd1);
        av[d] = 1'b1; addr[d] = a; dv[d] = we; wd[d] = data; sr[d] = 1'b1;
        tick();
        av[d] = 1'b0; dv[d] = 1'b0;
        chk("ready_busy", 32'(rdy[d]), 32'd0);
        n = 0;
        while (!sv[d] && n < 20) begin
            tick();
            n++;
        end
        chk("latency", 32'(n), 32'(lat - 1));
        chk("resp_data", sd[d], exp);
        tick();
        chk("valid_clr", 32'(sv[d]), 32'd0);
        chk("ready_back", 32'(rdy[d]), 32'd1);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; av[d] = 1'b0; addr[d] = '0; dv[d] = 1'b0; wd[d] = '0; sr[d] = 1'b0;
        end
        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            chk("rst_ready", 32'(rdy[d]), 32'd0);
            chk("rst_valid", 32'(sv[d]), 32'd0);
            chk("rst_data", sd[d], 32'h0);
        end
        rst[0] = 1'b0; rst[1] = 1'b0;
        tick();

        // Write, read back, and aliased read through the upper address bits.
        xact(0, 32'h5, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 2);
        xact(0, 32'h5, 1'b0, 32'h0, 32'hDEADBEEF, 2);
`ifdef MC_BOUNDS_CHECK_EN
        xact(0, 32'h405, 1'b0, 32'h0, 32'hFFFFFFFF, 2);
`else
        xact(0, 32'h405, 1'b0, 32'h0, 32'hDEADBEEF, 2);
`endif

        // Back-pressure with a second request held valid underneath.
        sr[0] = 1'b0; av[0] = 1'b1; addr[0] = 32'h5; dv[0] = 1'b0;
        tick();
        addr[0] = 32'h6; dv[0] = 1'b1; wd[0] = 32'h00000066;
        chk("bp_wait_valid", 32'(sv[0]), 32'd0);
        tick();
        chk("bp_first_valid", 32'(sv[0]), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_valid", 32'(sv[0]), 32'd1);
            chk("bp_hold_data", sd[0], 32'hDEADBEEF);
            chk("bp_hold_ready", 32'(rdy[0]), 32'd0);
        end
        sr[0] = 1'b1;
        tick();
        chk("bp_release_valid", 32'(sv[0]), 32'd0);
        chk("bp_release_ready", 32'(rdy[0]), 32'd1);
        tick();
        chk("bp_accept", 32'(rdy[0]), 32'd0);
        av[0] = 1'b0; dv[0] = 1'b0;
        tick();
        chk("bp_second_valid", 32'(sv[0]), 32'd1);
        chk("bp_second_data", sd[0], 32'h00000066);
        tick();
        chk("bp_second_clr", 32'(sv[0]), 32'd0);

        // Reset while waiting: response dropped, write retained.
        av[0] = 1'b1; addr[0] = 32'h7; dv[0] = 1'b1; wd[0] = 32'h12345678; sr[0] = 1'b1;
        tick();
        av[0] = 1'b0; dv[0] = 1'b0;
        chk("rstmid_wait", 32'(sv[0]), 32'd0);
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        base = resp_cnt[0];
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rstmid_no_valid", 32'(sv[0]), 32'd0);
        end
        chk("rstmid_resp_cnt", 32'(resp_cnt[0] - base), 32'd0);
        xact(0, 32'h7, 1'b0, 32'h0, 32'h12345678, 2);

`ifdef MC_BOUNDS_CHECK_EN
        xact(0, 32'h0, 1'b1, 32'h11112222, 32'h11112222, 2);
        xact(0, 32'h400, 1'b1, 32'hAAAA5555, 32'hFFFFFFFF, 2);
        xact(0, 32'h0, 1'b0, 32'h0, 32'h11112222, 2);
`endif

        // Latency 1: two back-to-back requests, exactly two responses.
        xact(1, 32'h3, 1'b1, 32'h0BADF00D, 32'h0BADF00D, 1);
        xact(1, 32'h4, 1'b1, 32'h01234567, 32'h01234567, 1);
        base = resp_cnt[1];
        sr[1] = 1'b1; av[1] = 1'b1; addr[1] = 32'h3; dv[1] = 1'b0;
        tick();
        chk("l1_first_valid", 32'(sv[1]), 32'd1);
        chk("l1_first_data", sd[1], 32'h0BADF00D);
        chk("l1_first_ready", 32'(rdy[1]), 32'd0);
        addr[1] = 32'h4;
        tick();
        chk("l1_gap_valid", 32'(sv[1]), 32'd0);
        chk("l1_gap_ready", 32'(rdy[1]), 32'd1);
        tick();
        chk("l1_second_valid", 32'(sv[1]), 32'd1);
        chk("l1_second_data", sd[1], 32'h01234567);
        av[1] = 1'b0;
        tick();
        chk("l1_second_clr", 32'(sv[1]), 32'd0);
        tick();
        tick();
        chk("l1_idle_valid", 32'(sv[1]), 32'd0);
        chk("l1_resp_cnt", 32'(resp_cnt[1] - base), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_responder.md
Name: mc_responder

Overview:
- Memory-side endpoint of the memory-controller request/response protocol.
- Accepts one request at a time from the arbiter's master port: an address, plus optional write data.
- Performs a read or write on an internal word-addressed RAM.
- Returns exactly one response per request after a programmable access latency.
- Every request, including writes, gets a response, so the upstream arbiter can release its grant.

Parameters:
- ADDR_WIDTH, 32, request address width (word address).
- DATA_WIDTH, 32, data word width.
- DEPTH_LOG2, 10, RAM holds 2**DEPTH_LOG2 words.
- ACCESS_LATENCY, 2, cycles from request accept to response valid; legal range 1..15.

Ports:
- CLK  in  1  clock; all logic on posedge.
- RST  in  1  synchronous, active-high reset.
- SLAVE_RECEIVE_ADDR_VALID  in  1  request present.
- SLAVE_RECEIVE_ADDR  in  ADDR_WIDTH  word address.
- SLAVE_RECEIVE_DATA_VALID  in  1  request is a write; sampled with the address.
- SLAVE_RECEIVE_DATA  in  DATA_WIDTH  write data.
- SLAVE_RECEIVE_READY  out  1  request accepted when high together with ADDR_VALID.
- SLAVE_SEND_VALID  out  1  response present.
- SLAVE_SEND_DATA  out  DATA_WIDTH  read data, or echo of write data.
- SLAVE_SEND_READY  in  1  response consumed when high together with SEND_VALID.

Behaviour:
- Clock and reset: one clock, CLK. Reset RST is synchronous and active-high.
- States:
  - S_IDLE: READY=1.
  - S_WAIT: latency countdown.
  - S_RESP: SEND_VALID=1.
- Reset:
  - State goes to S_IDLE; SEND_VALID=0; SEND_DATA=0; latency counter=0.
  - READY is forced 0 while RST is high.
  - RAM contents are not reset.
- Accept: in the cycle where ADDR_VALID && READY (edge T):
  - Index = ADDR[DEPTH_LOG2-1:0].
  - If DATA_VALID=1: mem[index] <= DATA, and the response register <= DATA (write echo).
  - If DATA_VALID=0: the response register <= mem[index], read before any write in the same edge.
  - DATA_VALID sampled without ADDR_VALID is ignored.
- Latency:
  - ACCESS_LATENCY=1: S_IDLE -> S_RESP directly, so SEND_VALID is high in cycle T+1.
  - Otherwise: S_IDLE -> S_WAIT with the counter loaded to ACCESS_LATENCY-2. Decrement each cycle; at 0 go to S_RESP.
  - In all cases SEND_VALID first goes high at T+ACCESS_LATENCY.
- Response hold:
  - In S_RESP, SEND_VALID and SEND_DATA stay stable until SEND_VALID && SEND_READY.
  - On that handshake, go to S_IDLE and clear SEND_VALID.
  - READY is high again the next cycle, so back-to-back throughput is one request per ACCESS_LATENCY+1 cycles minimum.
- Stalls and ordering:
  - READY=0 in S_WAIT and S_RESP; an upstream ADDR_VALID held there is simply stalled, not dropped.
  - Read-after-write to the same address always returns the new value, because the write commits at accept.
- Address handling: address bits above DEPTH_LOG2 are ignored, so addresses wrap modulo the depth. This is changed by the optional feature.
- Reset mid-operation: any pending response is discarded and no response is ever issued for it. A write already accepted remains committed.
- SEND_READY asserted while SEND_VALID=0: no effect.

Optional Feature:
- Macro: MC_BOUNDS_CHECK_EN.
- When defined:
  - An address >= 2**DEPTH_LOG2 (any upper bit set) is out of range.
  - Out-of-range writes are dropped: RAM unchanged, response = MC_ERR_WORD.
  - Out-of-range reads respond MC_ERR_WORD, which is all ones.
  - Timing and handshake are unchanged.
- When undefined: address wrap-around as above; no comparator logic.

Decomposition:
- Package mc_pkg: state encodings S_IDLE/S_WAIT/S_RESP, the LAT_CNT_W=4 counter width constant, and MC_ERR_WORD.
- Sub-module mc_ram:
  - Single-port, 2**DEPTH_LOG2 x DATA_WIDTH.
  - Synchronous write enable; read-before-write synchronous read.
  - No reset.
- mc_responder holds the FSM, latency counter, response register and bounds check.

Test Plan:
- Write addr 0x5, data 0xDEADBEEF, ACCESS_LATENCY=2, SEND_READY=1 -> READY drops after accept; SEND_VALID high exactly 2 cycles after accept with SEND_DATA=0xDEADBEEF; READY high the cycle after handshake.
- Then read addr 0x5 -> SEND_DATA=0xDEADBEEF. Read addr 0x405 with DEPTH_LOG2=10 and macro off -> also 0xDEADBEEF (wrap).
- Response back-pressure: SEND_READY=0 for 5 cycles -> SEND_VALID and SEND_DATA stable the whole time, READY stays 0, a new ADDR_VALID is not accepted; after SEND_READY=1 the next request is accepted one cycle later.
- ACCESS_LATENCY=1, read then immediate second request held valid -> responses at T+1 and at the second accept+1; exactly 2 responses.
- RST pulsed in S_WAIT after a write of 0x12345678 to addr 0x7 -> no SEND_VALID ever appears for it; a later read of 0x7 returns 0x12345678.
- With MC_BOUNDS_CHECK_EN: write 0xAAAA5555 to addr 0x400 -> response 0xFFFFFFFF; read of addr 0x0 is unchanged from its prior value.
